// File: rtl/fft_bfly_scheduler.sv
// fft_bfly_scheduler: sequencer for an in-place radix-2 DIT FFT datapath.
// Walks stage s, group g and butterfly k. For each butterfly it reads v then u,
// registers the multiply and the add/sub, then writes u then v back.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              start a transform (accepted only when idle)
//   stall_i              backpressure, honoured only at butterfly start (READ_V)
//   busy_o, done_o       transform in progress / one-cycle completion pulse
//   stage_o, tw_addr_o   current stage and twiddle ROM index
//   rd_en_o, rd_addr_o   RAM read strobe/address, rd_bank_o = s[0]
//   wr_en_o, wr_addr_o   RAM write strobe/address, wr_bank_o = ~s[0]
//   mul_en_o, addsub_en_o  datapath pipeline strobes
//   result_bank_o        bank holding the final spectrum
module fft_bfly_scheduler #(
    parameter int unsigned FFT_SIZE = 16,
    localparam int unsigned ADDR_W = $clog2(FFT_SIZE)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              stall_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] stage_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_bank_o,
    output logic [ADDR_W-1:0] tw_addr_o,
    output logic              mul_en_o,
    output logic              addsub_en_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              wr_bank_o,
    output logic              result_bank_o
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StReadV  = 3'd1;
    localparam logic [2:0] StReadU  = 3'd2;
    localparam logic [2:0] StMul    = 3'd3;
    localparam logic [2:0] StAddSub = 3'd4;
    localparam logic [2:0] StWriteU = 3'd5;
    localparam logic [2:0] StWriteV = 3'd6;
    localparam logic [2:0] StDone   = 3'd7;

    localparam logic [ADDR_W-1:0] HalfSize  = ADDR_W'(FFT_SIZE / 2);
    localparam logic [ADDR_W-1:0] LastStage = ADDR_W'(ADDR_W - 1);
    localparam logic [ADDR_W-1:0] One       = ADDR_W'(1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] s_q, s_d, g_q, g_d, k_q, k_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;

    logic [ADDR_W-1:0] span, u_addr, v_addr, n_groups, tw;
    logic              last_k, last_g, last_s;

    // Index math; all values fit in ADDR_W bits by construction.
    always_comb begin
        span     = One << s_q;
        u_addr   = (g_q << (s_q + One)) + k_q;
        v_addr   = u_addr + span;
        n_groups = HalfSize >> s_q;
        tw       = k_q << (LastStage - s_q);
        last_k   = (k_q == span - One);
        last_g   = (g_q == n_groups - One);
        last_s   = (s_q == LastStage);
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        g_d         = g_q;
        k_d         = k_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        rd_en_o     = 1'b0;
        wr_en_o     = 1'b0;
        mul_en_o    = 1'b0;
        addsub_en_o = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StReadV;
                    s_d     = '0;
                    g_d     = '0;
                    k_d     = '0;
                end
            end
            StReadV: begin
                if (!stall_i) begin
                    rd_en_o   = 1'b1;
                    rd_addr_d = v_addr;
                    state_d   = StReadU;
                end
            end
            StReadU: begin
                rd_en_o   = 1'b1;
                rd_addr_d = u_addr;
                state_d   = StMul;
            end
            StMul: begin
                mul_en_o = 1'b1;
                state_d  = StAddSub;
            end
            StAddSub: begin
                addsub_en_o = 1'b1;
                state_d     = StWriteU;
            end
            StWriteU: begin
                wr_en_o   = 1'b1;
                wr_addr_d = u_addr;
                state_d   = StWriteV;
            end
            StWriteV: begin
                wr_en_o   = 1'b1;
                wr_addr_d = v_addr;
                if (last_k && last_g && last_s) begin
                    state_d = StDone;
                end else begin
                    state_d = StReadV;
                    if (!last_k) begin
                        k_d = k_q + One;
                    end else begin
                        k_d = '0;
                        if (!last_g) begin
                            g_d = g_q + One;
                        end else begin
                            g_d = '0;
                            s_d = s_q + One;
                        end
                    end
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
                s_d     = '0;
                g_d     = '0;
                k_d     = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            s_q       <= '0;
            g_q       <= '0;
            k_q       <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            g_q       <= g_d;
            k_q       <= k_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    // The *_addr_d values equal the held register whenever the strobe is low.
    assign rd_addr_o     = rd_addr_d;
    assign wr_addr_o     = wr_addr_d;
    assign busy_o        = (state_q != StIdle);
    assign stage_o       = s_q;
    assign tw_addr_o     = tw;
    assign rd_bank_o     = s_q[0];
    // Gated so the idle value is 0 rather than ~s[0].
    assign wr_bank_o     = busy_o & ~s_q[0];
    assign result_bank_o = ADDR_W[0];

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
module tb_fft_bfly_scheduler;

    localparam int N  = 16;
    localparam int AW = 4;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic start_i = 1'b0;
    logic stall_i = 1'b0;
    logic no_stall = 1'b0;

    always #5 clk_i = ~clk_i;

    logic          busy, done, rd_en, rd_bank, mul, addsub, wr_en, wr_bank, res_bank;
    logic [AW-1:0] stage, rd_addr, tw, wr_addr;

    fft_bfly_scheduler #(.FFT_SIZE(N)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stall_i(stall_i),
        .busy_o(busy), .done_o(done), .stage_o(stage), .rd_en_o(rd_en),
        .rd_addr_o(rd_addr), .rd_bank_o(rd_bank), .tw_addr_o(tw), .mul_en_o(mul),
        .addsub_en_o(addsub), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
        .wr_bank_o(wr_bank), .result_bank_o(res_bank)
    );

    logic       busy4, done4, rd_en4, rd_bank4, mul4, addsub4, wr_en4, wr_bank4, res_bank4;
    logic [1:0] stage4, rd_addr4, tw4, wr_addr4;

    fft_bfly_scheduler #(.FFT_SIZE(4)) dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stall_i(no_stall),
        .busy_o(busy4), .done_o(done4), .stage_o(stage4), .rd_en_o(rd_en4),
        .rd_addr_o(rd_addr4), .rd_bank_o(rd_bank4), .tw_addr_o(tw4), .mul_en_o(mul4),
        .addsub_en_o(addsub4), .wr_en_o(wr_en4), .wr_addr_o(wr_addr4),
        .wr_bank_o(wr_bank4), .result_bank_o(res_bank4)
    );

    logic       busy8, done8, rd_en8, rd_bank8, mul8, addsub8, wr_en8, wr_bank8, res_bank8;
    logic [2:0] stage8, rd_addr8, tw8, wr_addr8;

    fft_bfly_scheduler #(.FFT_SIZE(8)) dut8 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stall_i(no_stall),
        .busy_o(busy8), .done_o(done8), .stage_o(stage8), .rd_en_o(rd_en8),
        .rd_addr_o(rd_addr8), .rd_bank_o(rd_bank8), .tw_addr_o(tw8), .mul_en_o(mul8),
        .addsub_en_o(addsub8), .wr_en_o(wr_en8), .wr_addr_o(wr_addr8),
        .wr_bank_o(wr_bank8), .result_bank_o(res_bank8)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [63:0] pack(input logic b, input logic d, input logic re,
                                         input logic [3:0] ra, input logic we,
                                         input logic [3:0] wa, input logic m, input logic a,
                                         input logic [3:0] t, input logic [3:0] st,
                                         input logic rb, input logic wb);
        return {40'b0, b, d, re, ra, we, wa, m, a, t, st, rb, wb};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       is_rv;
        logic       rd_en;
        logic [3:0] rd_addr;
        logic       wr_en;
        logic [3:0] wr_addr;
        logic       mul;
        logic       addsub;
        logic [3:0] tw;
        logic [3:0] stage;
    } rec_t;

    rec_t q[$];
    logic [3:0] hold_rd = '0;
    logic [3:0] hold_wr = '0;
    int mode = 0;  // 0 idle, 1 running, 2 done cycle

    function automatic rec_t mk(input logic rv, input logic re, input int ra, input logic we,
                                input int wa, input logic m, input logic a, input int t,
                                input int st);
        rec_t r;
        r.is_rv = rv; r.rd_en = re; r.rd_addr = 4'(ra); r.wr_en = we; r.wr_addr = 4'(wa);
        r.mul = m; r.addsub = a; r.tw = 4'(t); r.stage = 4'(st);
        return r;
    endfunction

    task automatic build();
        q.delete();
        for (int s = 0; s < AW; s++)
            for (int g = 0; g < (N >> (s + 1)); g++)
                for (int k = 0; k < (1 << s); k++) begin
                    int u, v, t;
                    u = g * (2 << s) + k;
                    v = u + (1 << s);
                    t = k * (N >> (s + 1));
                    q.push_back(mk(1, 1, v, 0, 0, 0, 0, t, s));
                    q.push_back(mk(0, 1, u, 0, 0, 0, 0, t, s));
                    q.push_back(mk(0, 0, 0, 0, 0, 1, 0, t, s));
                    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, t, s));
                    q.push_back(mk(0, 0, 0, 1, u, 0, 0, t, s));
                    q.push_back(mk(0, 0, 0, 1, v, 0, 0, t, s));
                end
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    initial forever begin
        logic [63:0] act, exp, msk;
        @(negedge clk_i);
        act = pack(busy, done, rd_en, rd_addr, wr_en, wr_addr, mul, addsub, tw, stage,
                   rd_bank, wr_bank);
        if (!rst_ni) begin
            mode = 0; q.delete(); hold_rd = '0; hold_wr = '0;
            check("reset_outputs", act, 64'd0);
        end else if (mode == 0) begin
            exp = pack(0, 0, 0, hold_rd, 0, hold_wr, 0, 0, 0, 0, 0, 0);
            msk = pack(1, 1, 1, '1, 1, '1, 1, 1, '1, '1, 0, 0);
            check("idle_cycle", act & msk, exp & msk);
            if (start_i) begin build(); mode = 1; end
        end else if (mode == 1) begin
            rec_t r;
            logic stalled, e_re;
            logic [3:0] e_ra, e_wa;
            r = q[0];
            stalled = r.is_rv && stall_i;
            e_re = r.rd_en && !stalled;
            e_ra = e_re ? r.rd_addr : hold_rd;
            e_wa = r.wr_en ? r.wr_addr : hold_wr;
            exp = pack(1, 0, e_re, e_ra, r.wr_en, e_wa, r.mul, r.addsub, r.tw, r.stage,
                       r.stage[0], ~r.stage[0]);
            check("run_cycle", act, exp);
            if (e_re) hold_rd = r.rd_addr;
            if (r.wr_en) hold_wr = r.wr_addr;
            if (!stalled) void'(q.pop_front());
            if (q.size() == 0) mode = 2;
        end else begin
            exp = pack(1, 1, 0, hold_rd, 0, hold_wr, 0, 0, 0, 0, 0, 0);
            msk = pack(1, 1, 1, '1, 1, '1, 1, 1, 0, 0, 0, 0);
            check("done_cycle", act & msk, exp & msk);
            mode = 0;
        end
    end

    // ---------------- event counters / traces ----------------
    int busy_c = 0, done_c = 0, mul_c = 0, add_c = 0, rd_c = 0, wr_c = 0, busy8_c = 0;
    int tw3_q[$], rd4_q[$], wr4_q[$], wb4_q[$], tw4_q[$], rb4_q[$];
    logic wb8_last = 1'b0;

    initial forever begin
        @(negedge clk_i);
        if (rst_ni) begin
            busy_c += int'(busy); done_c += int'(done); mul_c += int'(mul);
            add_c += int'(addsub); rd_c += int'(rd_en); wr_c += int'(wr_en);
            busy8_c += int'(busy8);
            if (mul && stage == 4'd3 && tw3_q.size() < 8) tw3_q.push_back(int'(tw));
            if (rd_en4 && rd4_q.size() < 8) rd4_q.push_back(int'(rd_addr4));
            if (wr_en4 && wr4_q.size() < 8) begin
                wr4_q.push_back(int'(wr_addr4));
                wb4_q.push_back(int'(wr_bank4));
            end
            if (mul4 && tw4_q.size() < 4) begin
                tw4_q.push_back(int'(tw4));
                rb4_q.push_back(int'(rd_bank4));
            end
            if (wr_en8 && stage8 == 3'd2) wb8_last = wr_bank8;
        end
    end

    task automatic pulse_start();
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            if (done) break;
        end
        check(nm, 64'(done), 64'd1);
    endtask

    int b0, d0, m0, a0, r0, w0, b80;
    task automatic snap();
        b0 = busy_c; d0 = done_c; m0 = mul_c; a0 = add_c; r0 = rd_c; w0 = wr_c; b80 = busy8_c;
    endtask

    initial begin
        int rd4_exp[8];
        int wr4_exp[8];
        int wb4_exp[8];
        int tw4_exp[4];
        int rb4_exp[4];
        rd4_exp = '{1, 0, 3, 2, 2, 0, 3, 1};
        wr4_exp = '{0, 1, 2, 3, 0, 2, 1, 3};
        wb4_exp = '{1, 1, 1, 1, 0, 0, 0, 0};
        tw4_exp = '{0, 0, 0, 1};
        rb4_exp = '{0, 0, 1, 1};

        repeat (3) @(negedge clk_i);
        check("result_bank_16", 64'(res_bank), 64'd0);
        check("result_bank_4", 64'(res_bank4), 64'd0);
        check("result_bank_8", 64'(res_bank8), 64'd1);
        #1 rst_ni = 1'b1;

        // Transform 1: clean run, all three sizes.
        snap();
        pulse_start();
        wait_done("t1_done_seen");
        pulse_start();  // back-to-back: start in the idle cycle after DONE
        check("t1_busy_cycles", 64'(busy_c - b0), 64'd193);
        check("t1_done_pulses", 64'(done_c - d0), 64'd1);
        check("t1_mul_pulses", 64'(mul_c - m0), 64'd32);
        check("t1_addsub_pulses", 64'(add_c - a0), 64'd32);
        check("t1_rd_pulses", 64'(rd_c - r0), 64'd64);
        check("t1_wr_pulses", 64'(wr_c - w0), 64'd64);
        check("t1_busy8_cycles", 64'(busy8_c - b80), 64'd73);
        check("n8_last_stage_wr_bank", 64'(wb8_last), 64'd1);
        check("stage3_tw_count", 64'(tw3_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) check($sformatf("stage3_tw[%0d]", i), 64'(tw3_q[i]), 64'(i));
        check("n4_rd_count", 64'(rd4_q.size()), 64'd8);
        check("n4_wr_count", 64'(wr4_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("n4_rd[%0d]", i), 64'(rd4_q[i]), 64'(rd4_exp[i]));
            check($sformatf("n4_wr[%0d]", i), 64'(wr4_q[i]), 64'(wr4_exp[i]));
            check($sformatf("n4_wr_bank[%0d]", i), 64'(wb4_q[i]), 64'(wb4_exp[i]));
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("n4_tw[%0d]", i), 64'(tw4_q[i]), 64'(tw4_exp[i]));
            check($sformatf("n4_rd_bank[%0d]", i), 64'(rb4_q[i]), 64'(rb4_exp[i]));
        end

        // Transform 2: 5-cycle stall in READ_V of butterfly 3, stall pulse during MUL.
        snap();
        for (int i = 0; i < 200 && (wr_c - w0) < 6; i++) @(negedge clk_i);
        check("t2_reach_bfly3", 64'(wr_c - w0), 64'd6);
        @(posedge clk_i); #1 stall_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1 stall_i = 1'b0;
        for (int i = 0; i < 20 && !mul; i++) @(negedge clk_i);
        check("t2_mul_seen", 64'(mul), 64'd1);
        #1 stall_i = 1'b1;
        @(posedge clk_i); #1 stall_i = 1'b0;
        wait_done("t2_done_seen");
        @(negedge clk_i);
        check("t2_busy_cycles", 64'(busy_c - b0), 64'd198);
        check("t2_done_pulses", 64'(done_c - d0), 64'd1);

        // Transform 3: start re-asserted during stage 2 is ignored.
        snap();
        pulse_start();
        for (int i = 0; i < 300 && stage != 4'd2; i++) @(negedge clk_i);
        check("t3_reach_stage2", 64'(stage), 64'd2);
        pulse_start();
        wait_done("t3_done_seen");
        repeat (4) @(negedge clk_i);
        check("t3_busy_cycles", 64'(busy_c - b0), 64'd193);
        check("t3_done_pulses", 64'(done_c - d0), 64'd1);

        // Transform 4: reset during stage-1 ADDSUB, then a clean rerun.
        snap();
        pulse_start();
        for (int i = 0; i < 300 && !(stage == 4'd1 && addsub); i++) @(negedge clk_i);
        check("t4_reach_s1_addsub", 64'(stage == 4'd1 && addsub), 64'd1);
        #1 rst_ni = 1'b0;
        #1 check("async_reset_outputs",
                 pack(busy, done, rd_en, rd_addr, wr_en, wr_addr, mul, addsub, tw, stage,
                      rd_bank, wr_bank), 64'd0);
        repeat (2) @(negedge clk_i);
        #1 rst_ni = 1'b1;
        check("t4_no_done", 64'(done_c - d0), 64'd0);
        snap();
        pulse_start();
        wait_done("t5_done_seen");
        @(negedge clk_i);
        check("t5_busy_cycles", 64'(busy_c - b0), 64'd193);
        check("t5_done_pulses", 64'(done_c - d0), 64'd1);
        check("t5_mul_pulses", 64'(mul_c - m0), 64'd32);
        check("t5_wr_pulses", 64'(wr_c - w0), 64'd64);

        repeat (2) @(negedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
